// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and request type for the register-file write-back scheduler
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-load busy vector with set/clear and four lookup ports
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       set_en_i,
    input  logic [REG_ADDR_W-1:0]      set_idx_i,
    input  logic                       clr_en_i,
    input  logic [REG_ADDR_W-1:0]      clr_idx_i,
    input  logic [3:0][REG_ADDR_W-1:0] lk_idx_i,
    output logic [3:0]                 lk_busy_o,
    output logic [NUM_REGS-1:0]        busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Set is applied after clear so a same-index issue wins over the returning load.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        lk_busy_o = '0;
        for (int i = 0; i < 4; i++) begin
            lk_busy_o[i] = busy_q[lk_idx_i[i]];
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - ALU/load write-port arbiter with load scoreboard; WB_FAIRNESS_EN adds ALU anti-starvation
module regfile_wb_scheduler
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    output logic                  dec_stall,
    output logic                  w_enabled,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [XLEN-1:0]       w_data,
    output logic [NUM_REGS-1:0]   busy_out
);

    if (STARVE_LIMIT < 0 || STARVE_LIMIT > 7) begin : g_limit_check
        $error("STARVE_LIMIT must fit the 3-bit starvation counter");
    end

    wb_req_t    alu_req, ld_req, win;
    logic [3:0] lk_busy;
    logic       alu_live, alu_grant, ld_grant, force_alu;

    assign alu_req = {alu_valid, alu_rd, alu_data};
    assign ld_req  = {ld_valid, ld_rd, ld_data};

    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .set_en_i  (issue_valid && issue_ready),
        .set_idx_i (issue_rd),
        .clr_en_i  (ld_grant),
        .clr_idx_i (ld_rd),
        .lk_idx_i  ({dec_rs2, dec_rs1, alu_rd, issue_rd}),
        .lk_busy_o (lk_busy),
        .busy_o    (busy_out)
    );

    // An ALU write to a register with a load in flight would be overwritten out of order.
    assign alu_live = alu_valid && !lk_busy[1];

`ifdef WB_FAIRNESS_EN
    logic [2:0] starve_q, starve_d;

    assign force_alu = alu_live && (starve_q == 3'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (alu_grant) begin
            starve_d = 3'd0;
        end else if (alu_live && ld_grant && starve_q != 3'd7) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_q <= 3'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_alu = 1'b0;
`endif

    assign ld_grant  = rstn && ld_valid && !force_alu;
    assign alu_grant = rstn && alu_live && !ld_grant;
    assign ld_ready  = ld_grant;
    assign alu_ready = alu_grant;

    assign issue_ready = rstn && !lk_busy[0];

    always_comb begin
        win = '0;
        if (ld_grant) begin
            win = ld_req;
        end else if (alu_grant) begin
            win = alu_req;
        end
    end

    assign w_enabled = win.valid && (win.rd != '0);
    assign w_addr    = win.rd;
    assign w_data    = win.data;

    // Same-cycle load data is forwarded by the register file, so it releases the stall.
    assign dec_stall = !rstn
                    || (lk_busy[2] && !(ld_grant && ld_rd == dec_rs1))
                    || (lk_busy[3] && !(ld_grant && ld_rd == dec_rs2));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed and randomized checks of regfile_wb_scheduler against a behavioural model
module tb_regfile_wb_scheduler;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rstn;
    logic        alu_valid, ld_valid, issue_valid;
    logic [4:0]  alu_rd, ld_rd, issue_rd, dec_rs1, dec_rs2;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready, issue_ready, dec_stall, w_enabled;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [31:0] busy_out;

    int vectors;
    int miscompares;

    logic [31:0] m_busy;
    int          m_cnt;
    logic        e_alu, e_ld, e_iss, e_stall, e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    regfile_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_stall   (dec_stall),
        .w_enabled   (w_enabled),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .busy_out    (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a set of registers awaiting load data plus a count of lost ALU cycles.
    task automatic model_eval();
        logic live, frc;
        e_alu = 1'b0; e_ld = 1'b0; e_iss = 1'b0; e_stall = 1'b1;
        e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
        if (rstn) begin
            live = alu_valid && !m_busy[alu_rd];
            frc  = 1'b0;
`ifdef WB_FAIRNESS_EN
            frc = live && (m_cnt == LIMIT);
`endif
            e_ld  = ld_valid && !frc;
            e_alu = live && !e_ld;
            e_iss = !m_busy[issue_rd];
            if (e_ld) begin
                e_wen = (ld_rd != 0); e_waddr = ld_rd; e_wdata = ld_data;
            end else if (e_alu) begin
                e_wen = (alu_rd != 0); e_waddr = alu_rd; e_wdata = alu_data;
            end
            e_stall = (m_busy[dec_rs1] && !(e_ld && ld_rd == dec_rs1))
                   || (m_busy[dec_rs2] && !(e_ld && ld_rd == dec_rs2));
        end
    endtask

    task automatic model_commit();
        if (!rstn) begin
            m_busy = '0;
            m_cnt  = 0;
        end else begin
            if (e_ld) m_busy[ld_rd] = 1'b0;
            if (issue_valid && e_iss && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (e_alu) m_cnt = 0;
            else if (alu_valid && !m_busy[alu_rd] && e_ld && m_cnt < 7) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        issue_valid = 0; issue_rd = 0;
        dec_rs1 = 0; dec_rs2 = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        alu_valid = 1; alu_rd = 5'd2; ld_valid = 1; ld_rd = 5'd3; issue_valid = 1; issue_rd = 5'd4;
        #1;
        vectors++; if (alu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ready got %b want 0", alu_ready); end
        vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL reset_issue_ready got %b want 0", issue_ready); end
        vectors++; if (w_enabled !== 1'b0) begin miscompares++; $display("FAIL reset_w_enabled got %b want 0", w_enabled); end
        vectors++; if (dec_stall !== 1'b1) begin miscompares++; $display("FAIL reset_dec_stall got %b want 1", dec_stall); end
        tick(); tick();
        rstn = 1; idle();
        #1;
        vectors++; if (busy_out !== 32'h0) begin miscompares++; $display("FAIL reset_busy_out got %h want 0", busy_out); end
        vectors++; if (w_enabled !== 1'b0) begin miscompares++; $display("FAIL post_reset_w_enabled got %b want 0", w_enabled); end
        vectors++; if (dec_stall !== 1'b0) begin miscompares++; $display("FAIL post_reset_dec_stall got %b want 0", dec_stall); end
    endtask

    task automatic test_alu_write();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        vectors++; if (alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_ready got %b want 1", alu_ready); end
        vectors++; if ({w_enabled, w_addr, w_data} !== {1'b1, 5'd5, 32'h1234}) begin
            miscompares++; $display("FAIL alu_write got en=%b addr=%0d data=%h want en=1 addr=5 data=1234", w_enabled, w_addr, w_data); end
        tick(); idle();
    endtask

    task automatic test_load_hazard();
        issue_valid = 1; issue_rd = 5'd7;
        #1;
        vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL issue7_ready got %b want 1", issue_ready); end
        tick(); idle(); dec_rs1 = 5'd7;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (dec_stall !== 1'b1) begin miscompares++; $display("FAIL hazard_stall cyc %0d got %b want 1", c, dec_stall); end
            vectors++; if (busy_out[7] !== 1'b1) begin miscompares++; $display("FAIL busy7_set got %b want 1", busy_out[7]); end
            tick();
        end
        ld_valid = 1; ld_rd = 5'd7; ld_data = 32'hDEAD;
        #1;
        vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL ld7_ready got %b want 1", ld_ready); end
        vectors++; if (dec_stall !== 1'b0) begin miscompares++; $display("FAIL grant_cycle_stall got %b want 0", dec_stall); end
        vectors++; if ({w_enabled, w_addr, w_data} !== {1'b1, 5'd7, 32'hDEAD}) begin
            miscompares++; $display("FAIL ld7_write got en=%b addr=%0d data=%h want en=1 addr=7 data=dead", w_enabled, w_addr, w_data); end
        tick(); idle(); dec_rs1 = 5'd7;
        #1;
        vectors++; if (busy_out[7] !== 1'b0) begin miscompares++; $display("FAIL busy7_clear got %b want 0", busy_out[7]); end
        vectors++; if (dec_stall !== 1'b0) begin miscompares++; $display("FAIL after_ld_stall got %b want 0", dec_stall); end
        idle();
    endtask

    task automatic test_priority();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA3;
        ld_valid = 1; ld_rd = 5'd4; ld_data = 32'hB4;
        #1;
        vectors++; if ({ld_ready, alu_ready, w_addr} !== {1'b1, 1'b0, 5'd4}) begin
            miscompares++; $display("FAIL prio_first got ld=%b alu=%b addr=%0d want ld=1 alu=0 addr=4", ld_ready, alu_ready, w_addr); end
        tick(); ld_valid = 0;
        #1;
        vectors++; if ({alu_ready, w_enabled, w_addr} !== {1'b1, 1'b1, 5'd3}) begin
            miscompares++; $display("FAIL prio_second got alu=%b en=%b addr=%0d want alu=1 en=1 addr=3", alu_ready, w_enabled, w_addr); end
        tick(); idle();
    endtask

    task automatic test_x0();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        issue_valid = 1; issue_rd = 5'd0;
        #1;
        vectors++; if ({alu_ready, issue_ready, w_enabled} !== 3'b110) begin
            miscompares++; $display("FAIL x0_grant got alu=%b iss=%b en=%b want alu=1 iss=1 en=0", alu_ready, issue_ready, w_enabled); end
        tick(); idle();
        #1;
        vectors++; if (busy_out !== 32'h0) begin miscompares++; $display("FAIL x0_busy got %h want 0", busy_out); end
    endtask

    task automatic test_waw();
        issue_valid = 1; issue_rd = 5'd9;
        tick(); idle();
        alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99; issue_valid = 1; issue_rd = 5'd9;
        #1;
        vectors++; if ({alu_ready, issue_ready, w_enabled} !== 3'b000) begin
            miscompares++; $display("FAIL waw_block got alu=%b iss=%b en=%b want 0 0 0", alu_ready, issue_ready, w_enabled); end
        tick(); issue_valid = 0;
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h900D;
        #1;
        vectors++; if ({ld_ready, alu_ready} !== 2'b10) begin
            miscompares++; $display("FAIL waw_return got ld=%b alu=%b want ld=1 alu=0", ld_ready, alu_ready); end
        tick(); ld_valid = 0;
        #1;
        vectors++; if ({alu_ready, w_enabled, w_addr, w_data} !== {1'b1, 1'b1, 5'd9, 32'h99}) begin
            miscompares++; $display("FAIL waw_release got alu=%b en=%b addr=%0d data=%h want 1 1 9 99", alu_ready, w_enabled, w_addr, w_data); end
        tick(); idle();
    endtask

    task automatic test_back_to_back();
        for (int c = 1; c <= 6; c++) begin
            logic want_alu;
            alu_valid = 1; alu_rd = 5'd10; alu_data = 32'(c);
            ld_valid = 1; ld_rd = 5'(20 + c); ld_data = 32'(100 + c);
            want_alu = 1'b0;
`ifdef WB_FAIRNESS_EN
            want_alu = (c == LIMIT + 1);
`endif
            #1;
            vectors++; if ({alu_ready, ld_ready} !== {want_alu, !want_alu}) begin
                miscompares++; $display("FAIL b2b cyc %0d got alu=%b ld=%b want alu=%b ld=%b", c, alu_ready, ld_ready, want_alu, !want_alu); end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rstn        = ($urandom_range(0, 59) != 0);
            alu_valid   = 1'($urandom_range(0, 1));
            alu_rd      = 5'($urandom_range(0, 11));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 2) == 0);
            ld_rd       = 5'($urandom_range(0, 11));
            ld_data     = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 11));
            dec_rs1     = 5'($urandom_range(0, 11));
            dec_rs2     = 5'($urandom_range(0, 11));
            #1;
            model_eval();
            vectors++; if ({alu_ready, ld_ready, issue_ready, dec_stall} !== {e_alu, e_ld, e_iss, e_stall}) begin
                miscompares++; $display("FAIL rnd_ctrl %0d got alu/ld/iss/stall=%b%b%b%b want %b%b%b%b", n,
                    alu_ready, ld_ready, issue_ready, dec_stall, e_alu, e_ld, e_iss, e_stall); end
            vectors++; if (w_enabled !== e_wen || (e_wen && (w_addr !== e_waddr || w_data !== e_wdata))) begin
                miscompares++; $display("FAIL rnd_wport %0d got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", n,
                    w_enabled, w_addr, w_data, e_wen, e_waddr, e_wdata); end
            if (rstn) begin
                vectors++; if (busy_out !== m_busy) begin
                    miscompares++; $display("FAIL rnd_busy %0d got %h want %h", n, busy_out, m_busy); end
            end
            tick();
        end
        rstn = 1; idle();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_busy = '0; m_cnt = 0;
        rstn = 0; idle();
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_load_hazard();
        test_priority();
        test_x0();
        test_waw();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 integer register file. It shares the file's single write port between the ALU write-back path and the load-unit write-back path, and keeps a pending-load scoreboard that stalls decode on read-after-load hazards. It sits between the execute/memory stages and the register file, driving the file's `w_enabled`/`w_addr`/`w_data` port.

## Interface
- `STARVE_LIMIT`, default 4: consecutive lost ALU arbitration cycles before the ALU is forced to win (used only with the fairness feature).
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `alu_valid` in 1: ALU write-back request.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `alu_ready` out 1: ALU request accepted this cycle.
- `ld_valid` in 1: load write-back request.
- `ld_rd` in 5: load destination register.
- `ld_data` in 32: load data.
- `ld_ready` out 1: load request accepted this cycle.
- `issue_valid` in 1: a load is being issued.
- `issue_rd` in 5: destination register of the issued load.
- `issue_ready` out 1: load issue permitted.
- `dec_rs1` in 5: decode-stage source 1 address.
- `dec_rs2` in 5: decode-stage source 2 address.
- `dec_stall` out 1: decode must hold.
- `w_enabled` out 1: register file write enable.
- `w_addr` out 5: register file write address.
- `w_data` out 32: register file write data.
- `busy_out` out 32: scoreboard vector, for debug.

## Operation
- Scoreboard `busy[31:0]`:
  - Set `busy[issue_rd]` on `issue_valid && issue_ready`, when `issue_rd != 0`.
  - Clear `busy[ld_rd]` on a load grant.
  - If set and clear hit the same index in the same cycle, set wins.
  - `busy[0]` is always 0.
- `issue_ready = !busy[issue_rd]`. One outstanding load per register.
- Arbitration is combinational:
  - Load has priority: `ld_ready = ld_valid`, and `alu_ready = alu_valid && !ld_valid`. The fairness override (see Configuration) changes this.
  - WAW guard: `alu_ready` is 0 while `busy[alu_rd]` is set. A blocked ALU request does not count as a lost cycle.
- Write port:
  - `w_enabled` = granted request with rd ≠ 0.
  - `w_addr`/`w_data` = granted rd/data, otherwise 0.
  - A request to x0 is granted (ready = 1) but `w_enabled` stays 0.
- `dec_stall` = (`busy[dec_rs1]` and not cleared this cycle) OR (same for `dec_rs2`). A load grant in the same cycle does not stall, because the register file forwards same-cycle writes.
- Reset while `rstn` = 0 forces:
  - all ready outputs to 0
  - `w_enabled` to 0
  - `dec_stall` to 1
  - `busy_out` to 0 and the starvation counter to 0 on the next edge

  Outstanding loads are discarded; the pipeline flushes with reset.

## Timing
- Grant, write port and stall are combinational in the same cycle. The register file commits the write at the next `clk` edge.
- A scoreboard update issued in cycle N is visible in `busy_out`/`issue_ready`/`dec_stall` in cycle N+1.
- Values after reset: `busy_out` = 0, counter = 0, `w_enabled` = 0.
- Back-to-back loads: one grant per cycle, no bubble.
- Issue and return of the same rd in the same cycle: bit ends up set, and the earlier instance is cleared by its own data.

## Configuration
- `WB_FAIRNESS_EN` defined:
  - A 3-bit saturating counter increments each cycle that `alu_valid` is non-blocked and loses to a load.
  - The counter resets to 0 on any ALU grant.
  - When counter == `STARVE_LIMIT`, the ALU wins and `ld_ready` is 0 for that cycle.
- `WB_FAIRNESS_EN` undefined: strict load priority, no counter logic.

## Structure
- Shared package `wb_pkg` holds:
  - `REG_ADDR_W` = 5, `XLEN` = 32, `NUM_REGS` = 32
  - typedef `wb_req_t` {valid, rd, data}
- One sub-module, `wb_scoreboard`: busy vector with set/clear/lookup ports. The top level holds the arbiter and counter.

## Test plan
- Reset held, then released: `busy_out` = 0, `w_enabled` = 0. ALU write x5 = 0x1234 gives `w_enabled` = 1, `w_addr` = 5.
- Issue load to x7, then decode with rs1 = 7: `dec_stall` = 1 until `ld_valid` x7 = 0xDEAD is granted. In the grant cycle `dec_stall` = 0; next cycle `busy[7]` = 0.
- ALU and load valid together (rd 3, rd 4): load written first, ALU written the next cycle.
- ALU write to x0, and issue to x0: both granted, `w_enabled` = 0, `busy[0]` stays 0.
- With `WB_FAIRNESS_EN` and `STARVE_LIMIT` = 4, ALU and load valid continuously: ALU is granted on the 5th cycle, then the counter returns to 0.
- ALU write to busy x9: `alu_ready` = 0 until the x9 load returns, then the ALU write is granted the next cycle. Also, `issue_rd` = 9 while x9 is busy gives `issue_ready` = 0.
